// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory-side controller: one outstanding op, lane placement,
// load extraction/extension and a per-state timeout.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of forcing them to alignment.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        is_load,
  input  logic        zero_ext,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_load_q, is_load_d, zext_q, zext_d;
  logic [1:0]       size_q, size_d, off_q, off_d;
  logic [29:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d, load_data_q, load_data_d;
  logic             load_valid_q, load_valid_d, bus_err_q, bus_err_d;
  logic             accept_c, trap_c, stall_c;
  logic [1:0]       off_c;
  logic [3:0]       be_c;
  logic [31:0]      shifted_c, ext_c;

  // Lane offset and byte enables of the incoming op (halves/words forced aligned)
  always_comb begin
    off_c = addr[1:0];
    be_c  = 4'b1111;
    case (size)
      2'b00: be_c = 4'b0001 << addr[1:0];
      2'b01: begin
        off_c = {addr[1], 1'b0};
        be_c  = 4'b0011 << off_c;
      end
      default: off_c = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  // A trapped op is killed upstream while the error pulses, so it is not re-accepted
  assign trap_c   = ((size == 2'b01) & addr[0]) | (size[1] & (|addr[1:0]));
  assign accept_c = op_valid & ~mis_q;
  assign mis_d    = (state_q == IDLE) & accept_c & trap_c;

  // Misalign error pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
  assign misalign_err = mis_q;
`else
  assign trap_c       = 1'b0;
  assign accept_c     = op_valid;
  assign misalign_err = 1'b0;
`endif

  // Extract the addressed lane from the read word and extend it
  always_comb begin
    shifted_c = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ext_c = {{24{shifted_c[7] & ~zext_q}}, shifted_c[7:0]};
      2'b01:   ext_c = {{16{shifted_c[15] & ~zext_q}}, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  // Next-state, capture and completion logic
  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    zext_d       = zext_q;
    size_d       = size_q;
    off_d        = off_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    stall_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          stall_c   = 1'b1;
          is_load_d = is_load;
          zext_d    = zero_ext;
          size_d    = size;
          off_d     = off_c;
          addr_d    = addr[31:2];
          be_d      = be_c;
          wdata_d   = wdata << {off_c, 3'b000};
          if (!trap_c) state_d = REQ;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (mem_gnt) begin
          if (is_load_q) begin
            state_d = RESP;
          end else begin
            state_d = IDLE;
            stall_c = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          stall_c   = 1'b0;
        end
      end
      RESP: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          state_d      = IDLE;
          load_data_d  = ext_c;
          load_valid_d = 1'b1;
          stall_c      = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          stall_c   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = ((state_q == IDLE) || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      zext_q       <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      zext_q       <= zext_d;
      size_q       <= size_d;
      off_q        <= off_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign stall      = stall_c & ~rst;
  assign mem_req    = (state_q == REQ);
  assign mem_we     = (state_q == REQ) & ~is_load_q;
  assign mem_addr   = {addr_q, 2'b00};
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;

endmodule
